i2c_slv_rx_fifo_irq: RTL and testbench
======================================

Name: i2c_slv_rx_fifo_irq

Overview:
Receive back-end for the BMC-facing I2C slave peripheral on the SoC APB bus. It consumes the byte and bus-event strobes from the I2C slave bit-level protocol engine, matches the slave address, and answers each byte with ACK/NACK. Accepted write data is buffered in an RX FIFO that software drains. An interrupt is raised on FIFO level threshold, end of transaction (STOP) or overflow, gated by the R3 interrupt-enable bit.

Parameters:
DEPTH, 16, RX FIFO depth in bytes; power of two, at least 2.
AW, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
clk_i  in  1  SoC peripheral clock.
rst_ni  in  1  Reset; synchronous, active-low.
slv_addr_i  in  7  Programmed 7-bit slave address (register-sourced, quasi-static).
start_i  in  1  One-cycle strobe: START or repeated START detected on the bus.
stop_i  in  1  One-cycle strobe: STOP detected on the bus.
byte_valid_i  in  1  One-cycle strobe: a full byte was shifted in from the bus.
byte_i  in  8  Received byte, MSB first as sent on the bus; valid with byte_valid_i.
ack_o  out  1  ACK decision for the current byte (1 = ACK, 0 = NACK); meaningful only while byte_valid_i=1.
pop_i  in  1  Software read strobe on the RX data register; pops one byte.
rdata_o  out  8  FIFO head byte; 8'h00 when empty.
level_o  out  AW+1  Number of bytes in the FIFO (0..DEPTH).
empty_o  out  1  level_o == 0.
full_o  out  1  level_o == DEPTH.
irq_en_i  in  1  Interrupt enable (R3[0]).
irq_thresh_i  in  AW+1  Level threshold; 0 disables the level trigger.
irq_clr_i  in  1  Write-1-to-clear strobe for sticky stop_pend and ovf.
stop_pend_o  out  1  Sticky: a STOP ended a transaction that stored at least one byte.
ovf_o  out  1  Sticky: a data byte was dropped because the FIFO was full.
irq_o  out  1  Registered interrupt to the SoC event/IRQ unit.

Behaviour:
- Reset (rst_ni=0 at posedge):
  - state=IDLE; rptr, wptr and level cleared; stop_pend_o=0, ovf_o=0, irq_o=0.
  - The transaction byte counter is cleared.
  - Combinational outputs follow: empty_o=1, full_o=0, rdata_o=8'h00.
  - Reset mid-transaction discards FIFO contents. The bus engine resumes at the next START.
- FSM states: IDLE, ADDR, DATA, IGNORE.
  - Any state, stop_i=1 -> IDLE. If the prior state was DATA and txn_cnt>0, set stop_pend_o.
  - Any state, start_i=1 and stop_i=0 -> ADDR; txn_cnt cleared. Repeated START is legal from DATA or IGNORE.
  - If start_i and stop_i are asserted in the same cycle, stop_i wins.
  - A byte_valid_i in the same cycle as start_i or stop_i is ignored: no push, ack_o=0.
  - IDLE: byte_valid_i is ignored with ack_o=0.
  - ADDR + byte_valid_i: if byte_i[7:1]==slv_addr_i and byte_i[0]==0 (write), ack_o=1 and next state DATA. Otherwise ack_o=0 and next state IGNORE. Read direction is not serviced by this block.
  - DATA + byte_valid_i, FIFO not full: ack_o=1; push byte_i; txn_cnt++ (saturating at 8 bits).
  - DATA + byte_valid_i, FIFO full: ack_o=0; byte dropped; ovf_o set.
  - IGNORE: bytes dropped, ack_o=0, no flags change.
- ack_o is combinational from state, byte_i, full_o and byte_valid_i; it is 0 when byte_valid_i=0. The engine samples it in the same cycle.
- FIFO:
  - Write at posedge on push.
  - pop_i while empty is ignored.
  - Push and pop in the same cycle when not full and not empty: level unchanged, both pointers advance.
  - Push while full is judged before the same-cycle pop, so the byte is dropped even if pop_i=1.
  - Pointers wrap modulo DEPTH.
  - rdata_o is combinational mem[rptr], or 8'h00 when empty.
- Flags:
  - irq_clr_i=1 clears stop_pend_o and ovf_o at posedge.
  - A set event in the same cycle as irq_clr_i wins (flag ends 1).
- IRQ:
  - irq_o is registered, one cycle after its cause.
  - irq_o = irq_en_i & ((irq_thresh_i!=0 & level>=irq_thresh_i) | stop_pend_o | ovf_o), all evaluated on the updated values.
  - irq_o is level-type: it stays high until software drains below threshold and clears the flags.
  - irq_en_i=0 forces irq_o=0 on the next cycle; sticky flags are retained.

Test Plan:
1. slv_addr_i=7'h3A; START, byte 8'h74, bytes 8'h11,8'h22,8'h33, STOP, thresh=0, irq_en=1 -> ack 1,1,1,1; level_o=3; stop_pend_o=1; irq_o=1 one cycle after STOP; pops return 11,22,33 then 00 with empty_o=1.
2. Address 8'h76 (mismatch), then 8'h75 (read to own address), each followed by two data bytes -> all ack_o=0; level_o stays 0; no flags set; irq_o stays 0.
3. DEPTH=16, write 18 data bytes, no pops -> bytes 1-16 ACK; bytes 17-18 NACK; full_o=1; ovf_o=1; irq_o=1. irq_clr_i with FIFO still full -> ovf_o=0, but irq_o remains 1 only if thresh<=16 and thresh!=0.
4. thresh=4, irq_en=1, push 4 bytes without STOP -> irq_o rises the cycle after the 4th push. One pop -> level 3, irq_o falls the next cycle.
5. DATA with 2 bytes stored, repeated START then address 8'h74 and 1 byte, then STOP -> no stop_pend at the repeated START; level_o=3; stop_pend_o=1 only after STOP. Repeat with byte_valid_i coincident with stop_i -> that byte is not stored.
6. rst_ni=0 for one cycle mid-DATA with level 5 -> level 0; flags 0; state IDLE; the following data byte without START is NACKed.

Source files
------------

// File: rtl/i2c_slv_rx_fifo_irq.sv
// I2C slave receive back-end: address match, ACK/NACK decision, RX byte FIFO
// and level/STOP/overflow interrupt generation for software draining.
module i2c_slv_rx_fifo_irq #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [6:0]    slv_addr_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          byte_valid_i,
  input  logic [7:0]    byte_i,
  output logic          ack_o,
  input  logic          pop_i,
  output logic [7:0]    rdata_o,
  output logic [AW:0]   level_o,
  output logic          empty_o,
  output logic          full_o,
  input  logic          irq_en_i,
  input  logic [AW:0]   irq_thresh_i,
  input  logic          irq_clr_i,
  output logic          stop_pend_o,
  output logic          ovf_o,
  output logic          irq_o
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, IGNORE} state_t;

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  state_t        r_state;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [AW:0]   r_level;
  logic [7:0]    r_txn_cnt;
  logic          r_stop_pend;
  logic          r_ovf;
  logic          r_irq;

  logic          w_byte;
  logic          w_addr_ok;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic          w_stop_set;
  logic [AW:0]   w_level_nxt;
  logic          w_stop_pend_nxt;
  logic          w_ovf_nxt;
  logic          w_irq_nxt;

  // A byte strobe coinciding with a bus event belongs to no frame.
  assign w_byte    = byte_valid_i & ~start_i & ~stop_i;
  assign w_addr_ok = (byte_i[7:1] == slv_addr_i) & ~byte_i[0];
  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == FULL_LVL);
  assign w_push    = w_byte & (r_state == DATA) & ~w_full;
  assign w_drop    = w_byte & (r_state == DATA) & w_full;
  assign w_pop     = pop_i & ~w_empty;

  assign ack_o = w_byte & (((r_state == ADDR) & w_addr_ok) |
                           ((r_state == DATA) & ~w_full));

  assign w_level_nxt = r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);

  // Set events take priority over a same-cycle software clear.
  assign w_stop_set      = stop_i & (r_state == DATA) & (r_txn_cnt != 8'd0);
  assign w_stop_pend_nxt = w_stop_set | (r_stop_pend & ~irq_clr_i);
  assign w_ovf_nxt       = w_drop | (r_ovf & ~irq_clr_i);

  assign w_irq_nxt = irq_en_i &
                     (((irq_thresh_i != '0) & (w_level_nxt >= irq_thresh_i)) |
                      w_stop_pend_nxt | w_ovf_nxt);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_txn_cnt <= 8'd0;
    end else if (stop_i) begin
      r_state <= IDLE;
    end else if (start_i) begin
      r_state   <= ADDR;
      r_txn_cnt <= 8'd0;
    end else if (byte_valid_i) begin
      case (r_state)
        ADDR:    r_state <= w_addr_ok ? DATA : IGNORE;
        DATA:    if (w_push && (r_txn_cnt != 8'hFF)) r_txn_cnt <= r_txn_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rptr      <= '0;
      r_wptr      <= '0;
      r_level     <= '0;
      r_stop_pend <= 1'b0;
      r_ovf       <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_level     <= w_level_nxt;
      r_stop_pend <= w_stop_pend_nxt;
      r_ovf       <= w_ovf_nxt;
      r_irq       <= w_irq_nxt;
    end
  end

  // Storage carries no reset; the empty gate on rdata_o hides stale entries.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= byte_i;
  end

  assign rdata_o     = w_empty ? 8'h00 : r_mem[r_rptr];
  assign level_o     = r_level;
  assign empty_o     = w_empty;
  assign full_o      = w_full;
  assign stop_pend_o = r_stop_pend;
  assign ovf_o       = r_ovf;
  assign irq_o       = r_irq;

endmodule

// File: tb/tb_i2c_slv_rx_fifo_irq.sv
// Scoreboard bench for i2c_slv_rx_fifo_irq: stored bytes are queued when driven
// and compared on software pops; level tracks the queue size.
module tb_i2c_slv_rx_fifo_irq;
  localparam int DEPTH = 16;
  localparam int AW = $clog2(DEPTH);

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [6:0]    slv_addr_i;
  logic          start_i, stop_i, byte_valid_i, pop_i;
  logic [7:0]    byte_i;
  logic          ack_o;
  logic [7:0]    rdata_o;
  logic [AW:0]   level_o;
  logic          empty_o, full_o;
  logic          irq_en_i, irq_clr_i;
  logic [AW:0]   irq_thresh_i;
  logic          stop_pend_o, ovf_o, irq_o;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] sb [$];

  i2c_slv_rx_fifo_irq #(.DEPTH(DEPTH)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .slv_addr_i(slv_addr_i),
    .start_i(start_i), .stop_i(stop_i), .byte_valid_i(byte_valid_i),
    .byte_i(byte_i), .ack_o(ack_o), .pop_i(pop_i), .rdata_o(rdata_o),
    .level_o(level_o), .empty_o(empty_o), .full_o(full_o),
    .irq_en_i(irq_en_i), .irq_thresh_i(irq_thresh_i), .irq_clr_i(irq_clr_i),
    .stop_pend_o(stop_pend_o), .ovf_o(ovf_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_start();
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  task automatic bus_stop();
    stop_i = 1'b1; tick(); stop_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic exp_ack, input logic store, input string tag);
    byte_valid_i = 1'b1;
    byte_i = b;
    #1 chk(tag, ack_o, exp_ack);
    if (store) sb.push_back(b);
    tick();
    byte_valid_i = 1'b0;
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] exp;
    exp = (sb.size() != 0) ? sb.pop_front() : 8'h00;
    chk(tag, rdata_o, exp);
    pop_i = 1'b1; tick(); pop_i = 1'b0;
    chk({tag, "_lvl"}, level_o, sb.size());
  endtask

  task automatic clr();
    irq_clr_i = 1'b1; tick(); irq_clr_i = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    rst_ni = 1'b0; slv_addr_i = 7'h3A; start_i = 0; stop_i = 0;
    byte_valid_i = 0; byte_i = 8'h00; pop_i = 0;
    irq_en_i = 1'b1; irq_clr_i = 1'b0; irq_thresh_i = '0;
    tick(); tick();
    chk("rst_empty", empty_o, 1); chk("rst_full", full_o, 0);
    chk("rst_rdata", rdata_o, 8'h00); chk("rst_level", level_o, 0);
    chk("rst_irq", irq_o, 0); chk("rst_stp", stop_pend_o, 0); chk("rst_ovf", ovf_o, 0);
    rst_ni = 1'b1;
    send(8'h55, 0, 0, "idle_nack");

    // Plain write transaction
    bus_start();
    send(8'h74, 1, 0, "t1_addr");
    send(8'h11, 1, 1, "t1_d0"); send(8'h22, 1, 1, "t1_d1"); send(8'h33, 1, 1, "t1_d2");
    chk("t1_irq_pre", irq_o, 0); chk("t1_stp_pre", stop_pend_o, 0);
    bus_stop();
    chk("t1_level", level_o, 3); chk("t1_stp", stop_pend_o, 1); chk("t1_irq", irq_o, 1);
    pop_chk("t1_p0"); pop_chk("t1_p1"); pop_chk("t1_p2");
    chk("t1_empty_rd", rdata_o, 8'h00); chk("t1_empty", empty_o, 1);
    pop_chk("t1_p_empty");
    clr();
    chk("t1_clr_stp", stop_pend_o, 0); chk("t1_clr_irq", irq_o, 0);

    // Address mismatch and read direction
    bus_start();
    send(8'h76, 0, 0, "t2_badaddr"); send(8'hA1, 0, 0, "t2_ign0"); send(8'hA2, 0, 0, "t2_ign1");
    bus_start();
    send(8'h75, 0, 0, "t2_rdaddr"); send(8'hB1, 0, 0, "t2_ign2"); send(8'hB2, 0, 0, "t2_ign3");
    bus_stop();
    chk("t2_level", level_o, 0); chk("t2_stp", stop_pend_o, 0);
    chk("t2_ovf", ovf_o, 0); chk("t2_irq", irq_o, 0);

    // Overflow
    irq_thresh_i = 5'd16;
    bus_start();
    send(8'h74, 1, 0, "t3_addr");
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom_range(0, 255));
      send(d, 1, 1, "t3_fill");
    end
    chk("t3_full", full_o, 1);
    send(8'hC1, 0, 0, "t3_ovf0"); send(8'hC2, 0, 0, "t3_ovf1");
    chk("t3_ovf", ovf_o, 1); chk("t3_irq", irq_o, 1); chk("t3_level", level_o, 16);
    clr();
    chk("t3_clr_ovf", ovf_o, 0); chk("t3_clr_irq", irq_o, 1);
    byte_valid_i = 1'b1; byte_i = 8'hEE; pop_i = 1'b1;
    #1 chk("t3_fullpop_ack", ack_o, 0);
    chk("t3_fullpop_rd", rdata_o, sb.pop_front());
    tick();
    byte_valid_i = 1'b0; pop_i = 1'b0;
    chk("t3_fullpop_lvl", level_o, 15); chk("t3_fullpop_ovf", ovf_o, 1);
    byte_valid_i = 1'b1; byte_i = 8'h5C; pop_i = 1'b1;
    #1 chk("t3_pp_ack", ack_o, 1);
    chk("t3_pp_rd", rdata_o, sb.pop_front());
    sb.push_back(8'h5C);
    tick();
    byte_valid_i = 1'b0; pop_i = 1'b0;
    chk("t3_pp_lvl", level_o, 15);
    irq_thresh_i = '0;
    clr();
    chk("t3_thr0_irq", irq_o, 0);
    bus_stop();
    chk("t3_stp", stop_pend_o, 1); chk("t3_stp_irq", irq_o, 1);
    while (sb.size() != 0) pop_chk("t3_pop");
    chk("t3_empty", empty_o, 1);
    clr();
    chk("t3_end_irq", irq_o, 0);

    // Level threshold
    irq_thresh_i = 5'd4;
    bus_start();
    send(8'h74, 1, 0, "t4_addr");
    send(8'h41, 1, 1, "t4_d"); send(8'h42, 1, 1, "t4_d"); send(8'h43, 1, 1, "t4_d");
    chk("t4_irq3", irq_o, 0);
    send(8'h44, 1, 1, "t4_d");
    chk("t4_irq4", irq_o, 1);
    pop_chk("t4_pop");
    chk("t4_irq_fall", irq_o, 0);
    bus_stop();
    while (sb.size() != 0) pop_chk("t4_pop");
    clr();
    chk("t4_end_irq", irq_o, 0);

    // Repeated START and byte coincident with STOP
    irq_thresh_i = '0;
    bus_start();
    send(8'h74, 1, 0, "t5_addr");
    send(8'h51, 1, 1, "t5_d"); send(8'h52, 1, 1, "t5_d");
    bus_start();
    chk("t5_rs_stp", stop_pend_o, 0);
    send(8'h74, 1, 0, "t5_addr2");
    send(8'h53, 1, 1, "t5_d");
    chk("t5_level", level_o, 3); chk("t5_stp_pre", stop_pend_o, 0);
    bus_stop();
    chk("t5_stp", stop_pend_o, 1);
    clr();
    bus_start();
    send(8'h74, 1, 0, "t5_addr3");
    byte_valid_i = 1'b1; byte_i = 8'h5A; stop_i = 1'b1;
    #1 chk("t5_stopbyte_ack", ack_o, 0);
    tick();
    byte_valid_i = 1'b0; stop_i = 1'b0;
    chk("t5_stopbyte_lvl", level_o, 3); chk("t5_stopbyte_stp", stop_pend_o, 0);
    bus_start();
    byte_valid_i = 1'b1; byte_i = 8'h74; start_i = 1'b1;
    #1 chk("t5_startbyte_ack", ack_o, 0);
    tick();
    byte_valid_i = 1'b0; start_i = 1'b0;
    bus_stop();
    while (sb.size() != 0) pop_chk("t5_pop");

    // Reset mid-transaction
    bus_start();
    send(8'h74, 1, 0, "t6_addr");
    for (int i = 0; i < 5; i++) send(8'h60 + 8'(i), 1, 1, "t6_d");
    chk("t6_level5", level_o, 5);
    rst_ni = 1'b0; tick(); rst_ni = 1'b1;
    sb.delete();
    chk("t6_level", level_o, 0); chk("t6_empty", empty_o, 1); chk("t6_rdata", rdata_o, 0);
    chk("t6_stp", stop_pend_o, 0); chk("t6_ovf", ovf_o, 0); chk("t6_irq", irq_o, 0);
    send(8'h66, 0, 0, "t6_nack");
    chk("t6_level_after", level_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
